// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: owns the 0xFF46 source-page register, copies one page into OAM
// and shares the system bus between the DMA engine and the CPU.
module oam_dma_arbiter #(
  parameter int          DMA_LEN       = 160,
  parameter logic [15:0] DMA_DEST_BASE = 16'hFE00,
  parameter int          START_DELAY   = 4,
  parameter logic [15:0] REG_ADDR      = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        hi_rd,
  output logic        hi_wr,
  input  logic [7:0]  hi_din,
  output logic        dma_active
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [7:0] DLY_INIT = 8'(START_DELAY - 1);

  logic [1:0]  state;
  logic [1:0]  phase;
  logic [7:0]  dma_reg;
  logic [7:0]  idx;
  logic [7:0]  data;
  logic [7:0]  dly_cnt;
  logic        wr_hit_q;

  logic        reg_sel;
  logic        hi_sel;
  logic        wr_hit;
  logic        trig;
  logic [7:0]  src_hi;
  logic [15:0] src;
  logic [15:0] dst;

  assign reg_sel    = (cpu_a == REG_ADDR);
  assign hi_sel     = (cpu_a >= 16'hFF80);
  assign wr_hit     = cpu_wr && reg_sel;
  // Edge detect so a strobe held over several clocks starts only one copy.
  assign trig       = wr_hit && !wr_hit_q;
  // Pages 0xE0-0xFF alias onto echo RAM at 0xC0-0xDF.
  assign src_hi     = (dma_reg >= 8'hE0) ? (dma_reg & 8'hDF) : dma_reg;
  assign src        = {src_hi, idx};
  assign dst        = DMA_DEST_BASE + {8'h00, idx};
  assign dma_active = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= 2'd0;
      dma_reg  <= 8'hFF;
      idx      <= 8'h00;
      data     <= 8'h00;
      dly_cnt  <= 8'h00;
      wr_hit_q <= 1'b0;
    end else begin
      wr_hit_q <= wr_hit;
      if (trig) begin
        dma_reg <= cpu_dout;
        idx     <= 8'h00;
        phase   <= 2'd0;
        dly_cnt <= DLY_INIT;
        state   <= S_DELAY;
      end else begin
        case (state)
          S_DELAY: begin
            if (dly_cnt == 8'h00) begin
              state <= S_XFER;
              phase <= 2'd0;
            end else begin
              dly_cnt <= dly_cnt - 8'h01;
            end
          end
          S_XFER: begin
            phase <= phase + 2'd1;
            if (phase == 2'd1) data <= bus_din;
            if (phase == 2'd3) begin
              if (idx == LAST_IDX) state <= S_IDLE;
              else                 idx   <= idx + 8'h01;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus_a    = 16'h0000;
    bus_dout = 8'h00;
    bus_rd   = 1'b0;
    bus_wr   = 1'b0;
    hi_rd    = 1'b0;
    hi_wr    = 1'b0;
    cpu_din  = 8'hFF;
    if (reg_sel) begin
      cpu_din = dma_reg;
    end else if (hi_sel) begin
      hi_rd   = cpu_rd;
      hi_wr   = cpu_wr;
      cpu_din = hi_din;
    end else if (state != S_XFER) begin
      bus_a    = cpu_a;
      bus_dout = cpu_dout;
      bus_rd   = cpu_rd;
      bus_wr   = cpu_wr;
      cpu_din  = bus_din;
    end
    // DMA owns the bus in XFER; CPU low-page accesses were already dropped above.
    if (state == S_XFER) begin
      case (phase)
        2'd0, 2'd1: begin
          bus_a  = src;
          bus_rd = 1'b1;
        end
        2'd2: begin
          bus_a    = dst;
          bus_dout = data;
          bus_wr   = 1'b1;
        end
        default: ;
      endcase
    end
    if (rst) begin
      bus_a  = 16'h0000;
      bus_rd = 1'b0;
      bus_wr = 1'b0;
      hi_rd  = 1'b0;
      hi_wr  = 1'b0;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: bus/HRAM memory models, routing table, and page-copy
// runs checked against a page/offset reference of what OAM must contain.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'h00;
  logic        bus_rd, bus_wr, hi_rd, hi_wr;
  logic [7:0]  hi_din;
  logic        dma_active;

  logic [7:0]  mem   [0:65535];
  logic        wrote [0:65535];
  logic [7:0]  hram  [0:127];
  logic [7:0]  exp_oam [0:159];
  int unsigned seed = 0;

  int checks = 0, errors = 0;
  int act_cnt = 0, wr_total = 0;
  logic [15:0] wq[$], rq[$];

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd, wr;
    logic [7:0]  din;
    logic        brd, bwr, hrd, hwr;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .cpu_din(cpu_din), .bus_a(bus_a), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_rd(bus_rd), .bus_wr(bus_wr), .hi_rd(hi_rd),
    .hi_wr(hi_wr), .hi_din(hi_din), .dma_active(dma_active)
  );

  function automatic logic [7:0] gen(logic [15:0] a);
    if (seed == 0) return a[7:0] ^ 8'h5A;
    return 8'((32'(a) * 32'd2654435761 + seed) >> 13);
  endfunction

  function automatic logic [7:0] peek(logic [15:0] a);
    return wrote[a] ? mem[a] : gen(a);
  endfunction

  function automatic logic [7:0] src_page(logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  assign hi_din = hram[cpu_a[6:0]];

  // Bus RAM with one-cycle read latency, HRAM, and transaction logs.
  always @(posedge clk) begin
    if (bus_wr) begin
      mem[bus_a]   <= bus_dout;
      wrote[bus_a] <= 1'b1;
      wr_total = wr_total + 1;
    end
    bus_din <= peek(bus_a);
    if (hi_wr) hram[cpu_a[6:0]] <= cpu_dout;
    if (dma_active) act_cnt = act_cnt + 1;
    if (dma_active && bus_wr) wq.push_back(bus_a);
    if (dma_active && bus_rd) rq.push_back(bus_a);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(logic [15:0] a, logic [7:0] d, output int snap);
    @(negedge clk); cpu_a = a; cpu_dout = d; cpu_wr = 1'b1; cpu_rd = 1'b0;
    @(posedge clk); #1 snap = act_cnt;
    @(negedge clk); cpu_wr = 1'b0; cpu_a = 16'h0000;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (dma_active && n < 3000) begin @(negedge clk); n++; end
    chk({name, " completes"}, 32'(dma_active), 32'd0);
  endtask

  task automatic wait_wq(int target, string name);
    int n = 0;
    while (wq.size() < target && n < 3000) begin @(negedge clk); n++; end
    if (wq.size() < target) chk({name, " reach byte"}, 32'(wq.size()), 32'(target));
  endtask

  // Reference: OAM[i] must equal the source byte at {mapped page, i}.
  task automatic prep(logic [7:0] page, output int wb, output int rb, output int ab);
    for (int i = 0; i < 160; i++) exp_oam[i] = peek({src_page(page), 8'(i)});
    wb = wq.size(); rb = rq.size(); ab = act_cnt;
  endtask

  task automatic chk_oam(string name, int wb);
    int bad = 0, badord = 0;
    for (int i = 0; i < 160; i++)
      if (peek(16'hFE00 + 16'(i)) !== exp_oam[i]) bad++;
    chk({name, " oam data"}, 32'(bad), 32'd0);
    chk({name, " write count"}, 32'(wq.size() - wb), 32'd160);
    for (int i = 0; i < 160 && wb + i < wq.size(); i++)
      if (wq[wb + i] !== 16'hFE00 + 16'(i)) badord++;
    chk({name, " write order"}, 32'(badord), 32'd0);
  endtask

  task automatic read_reg(string name, logic [7:0] exp);
    @(negedge clk); cpu_a = 16'hFF46; cpu_rd = 1'b1;
    #1 chk(name, 32'(cpu_din), 32'(exp));
    @(negedge clk); cpu_rd = 1'b0; cpu_a = 16'h0000;
  endtask

  initial begin
    int wb, rb, ab, snap, fe32;
    logic [7:0] pg;
    tbl[0] = '{16'hC123, 8'h00, 1'b1, 1'b0, 8'h79, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'hFF90, 8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'hFF90, 8'h00, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'hFF7F, 8'h00, 1'b1, 1'b0, 8'h25, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'hC200, 8'h99, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'hC200, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 65536; i++) wrote[i] = 1'b0;

    // Reset forces strobes low even with the CPU requesting
    cpu_a = 16'hC123; cpu_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst bus_rd", 32'(bus_rd), 32'd0);
    chk("rst bus_a", 32'(bus_a), 32'd0);
    chk("rst dma_active", 32'(dma_active), 32'd0);
    cpu_a = 16'hFF90; #1 chk("rst hi_rd", 32'(hi_rd), 32'd0);
    @(negedge clk); rst = 1'b0; cpu_rd = 1'b0; cpu_a = 16'h0000;

    // Idle routing table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cpu_a = tbl[i].a; cpu_dout = tbl[i].d; cpu_rd = tbl[i].rd; cpu_wr = tbl[i].wr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d cpu_din", i), 32'(cpu_din), 32'(tbl[i].din));
      chk($sformatf("tbl%0d bus_rd", i), 32'(bus_rd), 32'(tbl[i].brd));
      chk($sformatf("tbl%0d bus_wr", i), 32'(bus_wr), 32'(tbl[i].bwr));
      chk($sformatf("tbl%0d hi_rd", i), 32'(hi_rd), 32'(tbl[i].hrd));
      chk($sformatf("tbl%0d hi_wr", i), 32'(hi_wr), 32'(tbl[i].hwr));
      if (tbl[i].brd || tbl[i].bwr) chk($sformatf("tbl%0d bus_a", i), 32'(bus_a), 32'(tbl[i].a));
    end
    @(negedge clk); cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 16'h0000;

    // Page 0xC0 copy with a CPU high-page write and blocked low access mid-transfer
    prep(8'hC0, wb, rb, ab);
    do_write(16'hFF46, 8'hC0, snap);
    wait_wq(wb + 5, "c0");
    cpu_a = 16'hFF85; cpu_dout = 8'h33; cpu_wr = 1'b1;
    #1 chk("xfer hi_wr", 32'(hi_wr), 32'd1);
    @(negedge clk); cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1 chk("xfer hram read", 32'(cpu_din), 32'h33);
    chk("xfer hi_rd", 32'(hi_rd), 32'd1);
    @(negedge clk); cpu_a = 16'h8000; cpu_dout = 8'h77; cpu_rd = 1'b1; cpu_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("xfer blocked din", 32'(cpu_din), 32'hFF);
      chk("xfer no cpu strobe", 32'(bus_a == 16'h8000 && (bus_rd || bus_wr)), 32'd0);
      @(negedge clk);
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 16'h0000;
    chk("xfer write dropped", 32'(wrote[16'h8000]), 32'd0);
    wait_idle("c0");
    chk("c0 active cycles", 32'(act_cnt - ab), 32'd644);
    chk_oam("c0", wb);
    read_reg("reg after c0", 8'hC0);

    // Echo-mapped page 0xFE reads from 0xDE00
    seed = $urandom | 1;
    prep(8'hFE, wb, rb, ab);
    do_write(16'hFF46, 8'hFE, snap);
    wait_idle("fe");
    chk("fe first read", 32'(rq.size() > rb ? rq[rb] : 16'h0), 32'hDE00);
    chk("fe last write", 32'(wq.size() > 0 ? wq[wq.size()-1] : 16'h0), 32'hFE9F);
    chk_oam("fe", wb);

    // Random pages and contents
    for (int r = 0; r < 3; r++) begin
      seed = $urandom | 1;
      pg = 8'($urandom_range(0, 255));
      prep(pg, wb, rb, ab);
      do_write(16'hFF46, pg, snap);
      wait_idle($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d active", r), 32'(act_cnt - ab), 32'd644);
      chk_oam($sformatf("rnd%0d pg%0h", r, pg), wb);
    end

    // Restart at idx 50 with page 0x80
    seed = $urandom | 1;
    prep(8'h80, wb, rb, ab);
    do_write(16'hFF46, 8'h40, snap);
    wait_wq(wb + 50, "restart");
    do_write(16'hFF46, 8'h80, snap);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("restart delay idle", 32'(bus_rd), 32'd0);
    end
    @(negedge clk);
    chk("restart first rd", 32'(bus_rd), 32'd1);
    chk("restart first addr", 32'(bus_a), 32'h8000);
    wait_idle("restart");
    chk("restart active", 32'(act_cnt - snap), 32'd644);
    fe32 = 0;
    for (int i = wb; i < wq.size(); i++) if (wq[i] == 16'hFE32) fe32++;
    chk("restart fe32 writes", 32'(fe32), 32'd1);
    chk("restart total writes", 32'(wq.size() - wb), 32'd210);
    chk_oam("restart", wb + 50);

    // Reset mid-byte aborts at once
    prep(8'hC0, wb, rb, ab);
    do_write(16'hFF46, 8'hC0, snap);
    wait_wq(wb + 10, "abort");
    @(negedge clk); @(negedge clk);
    chk("abort pre bus_rd", 32'(bus_rd), 32'd1);
    rst = 1'b1;
    #1 chk("abort bus_rd", 32'(bus_rd), 32'd0);
    chk("abort dma_active", 32'(dma_active), 32'd0);
    snap = wr_total;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort no writes", 32'(wr_total - snap), 32'd0);
    chk("abort stays idle", 32'(dma_active), 32'd0);
    read_reg("reg after reset", 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
